// File: rtl/rtc_write_sequencer_pkg.sv
// rtc_pkg: shared types and constants for the RTC write sequencer.
//   - Default bus timing (clocks per SETUP/STROBE/HOLD/GAP phase).
//   - Sequencer state enum and bus-cycle phase enum. The top-level
//     ADDR_* / DATA_* states are the pair (ST_ADDR_CYCLE / ST_DATA_CYCLE,
//     bus phase) so the four-phase timing lives in one place.
//   - reg_addr(): RTC register address for each table slot.
package rtc_pkg;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_STROBE_DEF = 4;
    localparam int unsigned T_HOLD_DEF   = 2;
    localparam int unsigned T_GAP_DEF    = 2;
    localparam int unsigned NUM_REGS_DEF = 7;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_ADDR_CYCLE = 3'd3,
        ST_DATA_CYCLE = 3'd4,
        ST_DONE       = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SETUP  = 3'd1,
        PH_STROBE = 3'd2,
        PH_HOLD   = 3'd3,
        PH_GAP    = 3'd4
    } bus_phase_t;

    // Slot 0 is the control/command register, slots 1..6 sec..year.
    function automatic logic [7:0] reg_addr(input logic [2:0] idx);
        logic [7:0] addr;
        case (idx)
            3'd0:    addr = 8'h02;
            3'd1:    addr = 8'h21;
            3'd2:    addr = 8'h22;
            3'd3:    addr = 8'h23;
            3'd4:    addr = 8'h24;
            3'd5:    addr = 8'h25;
            3'd6:    addr = 8'h26;
            default: addr = 8'h00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_write_sequencer_bus_cycle.sv
// rtc_bus_write_cycle: one RTC bus write cycle SETUP -> STROBE -> HOLD -> GAP.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   go             start a cycle (accepted when idle or in the last GAP clock)
//   a_d_val        0 = address cycle, 1 = data cycle (captured at go)
//   byte_val       byte to drive (captured at go)
//   cycle_done     high during the last GAP clock
//   a_d, cs_n, wr_n, bus_out, bus_oe   registered RTC bus outputs
module rtc_bus_write_cycle
    import rtc_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_STROBE = T_STROBE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       a_d_val,
    input  logic [7:0] byte_val,
    output logic       cycle_done,
    output logic       a_d,
    output logic       cs_n,
    output logic       wr_n,
    output logic [7:0] bus_out,
    output logic       bus_oe
);

    localparam logic [7:0] SETUP_LAST  = 8'(T_SETUP - 1);
    localparam logic [7:0] STROBE_LAST = 8'(T_STROBE - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(T_HOLD - 1);
    localparam logic [7:0] GAP_LAST    = 8'(T_GAP - 1);

    bus_phase_t phase_r, phase_s;
    logic [7:0] timer_r, timer_s;
    logic       load_s;
    logic       a_d_s;
    logic [7:0] bus_out_s;
    logic       cs_n_s, wr_n_s, bus_oe_s;

    // Kept outside the next-state block so the caller may derive go from it.
    assign cycle_done = (phase_r == PH_GAP) && (timer_r == GAP_LAST);

    // Next phase, timer reload on every phase entry, and next output values.
    always_comb begin
        phase_s = phase_r;
        timer_s = timer_r + 8'd1;
        load_s  = 1'b0;
        case (phase_r)
            PH_IDLE: begin
                timer_s = 8'd0;
                if (go) begin
                    phase_s = PH_SETUP;
                    load_s  = 1'b1;
                end else begin
                    phase_s = PH_IDLE;
                end
            end
            PH_SETUP: begin
                if (timer_r == SETUP_LAST) begin
                    phase_s = PH_STROBE;
                    timer_s = 8'd0;
                end else begin
                    phase_s = PH_SETUP;
                end
            end
            PH_STROBE: begin
                if (timer_r == STROBE_LAST) begin
                    phase_s = PH_HOLD;
                    timer_s = 8'd0;
                end else begin
                    phase_s = PH_STROBE;
                end
            end
            PH_HOLD: begin
                if (timer_r == HOLD_LAST) begin
                    phase_s = PH_GAP;
                    timer_s = 8'd0;
                end else begin
                    phase_s = PH_HOLD;
                end
            end
            PH_GAP: begin
                if (timer_r == GAP_LAST) begin
                    timer_s = 8'd0;
                    // Back-to-back cycles: the next SETUP follows the last GAP clock.
                    if (go) begin
                        phase_s = PH_SETUP;
                        load_s  = 1'b1;
                    end else begin
                        phase_s = PH_IDLE;
                    end
                end else begin
                    phase_s = PH_GAP;
                end
            end
            default: begin
                phase_s = PH_IDLE;
                timer_s = 8'd0;
            end
        endcase

        a_d_s     = load_s ? a_d_val : a_d;
        bus_out_s = load_s ? byte_val : bus_out;

        case (phase_s)
            PH_SETUP:  begin cs_n_s = 1'b1; wr_n_s = 1'b1; bus_oe_s = 1'b1;   end
            PH_STROBE: begin cs_n_s = 1'b0; wr_n_s = 1'b0; bus_oe_s = 1'b1;   end
            PH_HOLD:   begin cs_n_s = 1'b1; wr_n_s = 1'b1; bus_oe_s = 1'b1;   end
            // Bus stays driven between address and data, released after data.
            PH_GAP:    begin cs_n_s = 1'b1; wr_n_s = 1'b1; bus_oe_s = ~a_d_s; end
            default:   begin cs_n_s = 1'b1; wr_n_s = 1'b1; bus_oe_s = 1'b0;   end
        endcase
    end

    // Phase/timer registers and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= PH_IDLE;
            timer_r <= 8'd0;
            a_d     <= 1'b1;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            bus_out <= 8'h00;
            bus_oe  <= 1'b0;
        end else begin
            phase_r <= phase_s;
            timer_r <= timer_s;
            a_d     <= a_d_s;
            cs_n    <= cs_n_s;
            wr_n    <= wr_n_s;
            bus_out <= bus_out_s;
            bus_oe  <= bus_oe_s;
        end
    end

endmodule

// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: copies the 7-byte time/date image from local RAM
// into the RTC. Per table entry: fetch byte from RAM, address write cycle,
// data write cycle.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             request a full sequence (sampled only in IDLE)
//   busy, done        sequence in progress / one-clock completion pulse
//   ram_addr, ram_rd_en, ram_rdata   RAM read port (data one clock after strobe)
//   a_d, cs_n, rd_n, wr_n, bus_out, bus_oe   RTC bus toward the pads
module rtc_write_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_STROBE = T_STROBE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] ram_addr,
    output logic       ram_rd_en,
    input  logic [7:0] ram_rdata,
    output logic       a_d,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] bus_out,
    output logic       bus_oe
);

    localparam logic [2:0] LAST_INDEX = 3'(NUM_REGS - 1);

    seq_state_t state_r, state_s;
    logic [2:0] index_r, index_s;
    logic [7:0] data_reg_r;
    logic       go_s, a_d_val_s, cycle_done_s;
    logic [7:0] byte_s;

    assign rd_n = 1'b1;

    // Address cycle is launched from FETCH_WAIT, data cycle from the last ADDR_GAP clock.
    assign go_s      = (state_r == ST_FETCH_WAIT) ||
                       ((state_r == ST_ADDR_CYCLE) && cycle_done_s);
    assign a_d_val_s = (state_r == ST_ADDR_CYCLE);
    assign byte_s    = (state_r == ST_FETCH_WAIT) ? reg_addr(index_r) : data_reg_r;

    rtc_bus_write_cycle #(
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD),
        .T_GAP    (T_GAP)
    ) u_cycle (
        .clk        (clk),
        .reset      (reset),
        .go         (go_s),
        .a_d_val    (a_d_val_s),
        .byte_val   (byte_s),
        .cycle_done (cycle_done_s),
        .a_d        (a_d),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe)
    );

    // Sequencer next state and table index.
    always_comb begin
        state_s = state_r;
        index_s = index_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    index_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH:      state_s = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_s = ST_ADDR_CYCLE;
            ST_ADDR_CYCLE: begin
                if (cycle_done_s) begin
                    state_s = ST_DATA_CYCLE;
                end else begin
                    state_s = ST_ADDR_CYCLE;
                end
            end
            ST_DATA_CYCLE: begin
                if (cycle_done_s) begin
                    if (index_r == LAST_INDEX) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                        index_s = index_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA_CYCLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                index_s = 3'd0;
            end
            default: begin
                state_s = ST_IDLE;
                index_s = 3'd0;
            end
        endcase
    end

    // State register and registered control outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            index_r   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= 3'd0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            busy      <= (state_s != ST_IDLE);
            done      <= (state_s == ST_DONE);
            ram_rd_en <= (state_s == ST_FETCH);
            ram_addr  <= index_s;
        end
    end

    // RAM byte captured once per entry and held through both bus cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg_r <= 8'h00;
        end else if (state_r == ST_FETCH_WAIT) begin
            data_reg_r <= ram_rdata;
        end else begin
            data_reg_r <= data_reg_r;
        end
    end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: the driver pushes the expected
// bus writes and done cycles; a negedge monitor pops and compares them and
// checks strobe shape, setup/hold stability, rd_n and busy span.
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done;
    logic [2:0] ram_addr;
    logic       ram_rd_en;
    logic [7:0] ram_rdata;
    logic       a_d, cs_n, rd_n, wr_n, bus_oe;
    logic [7:0] bus_out;

    logic [7:0] mem      [0:6];
    logic [7:0] addr_tab [0:6];
    logic [7:0] ram_q = 8'h00;
    logic       override = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [8:0] exp_wr[$];
    int         exp_done[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid one clock after the read strobe.
    always @(posedge clk) if (ram_rd_en) ram_q <= mem[ram_addr];
    assign ram_rdata = override ? 8'hFF : ram_q;

    rtc_write_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_rd_en (ram_rd_en),
        .ram_rdata (ram_rdata),
        .a_d       (a_d),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected writes for one sequence whose start is driven at negedge cycle j.
    task automatic push_seq(input int j);
        for (int i = 0; i < 7; i++) begin
            exp_wr.push_back({1'b0, addr_tab[i]});
            exp_wr.push_back({1'b1, mem[i]});
        end
        exp_done.push_back(j + 155);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_wr.size() == 0 && exp_done.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk("drain_writes", exp_wr.size(), 0);
        chk("drain_done", exp_done.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor state
    logic       in_strobe = 1'b0, after_done = 1'b0;
    logic       last_ad = 1'b0, last_oe = 1'b0, s_ad = 1'b0;
    logic [7:0] last_bus = 8'h00, s_bus = 8'h00;
    int         run = 0, len = 0, post = 0, busy_run = 0;

    // Monitor: samples on the falling edge, pops the scoreboard on each strobe.
    always @(negedge clk) begin
        if (reset) begin
            in_strobe  = 1'b0;
            after_done = 1'b0;
            post = 0; run = 0; len = 0; busy_run = 0;
            last_oe = 1'b0;
        end else begin
            if (rd_n !== 1'b1) chk("rd_n_idle", rd_n, 1);
            if (!wr_n && cs_n) chk("wr_n_without_cs", wr_n, 1);
            if (bus_oe && last_oe && a_d == last_ad && bus_out == last_bus) run++;
            else run = bus_oe ? 1 : 0;
            last_ad = a_d; last_bus = bus_out; last_oe = bus_oe;

            if (!cs_n) begin
                if (!in_strobe) begin
                    in_strobe = 1'b1;
                    len = 0;
                    s_ad = a_d;
                    s_bus = bus_out;
                    chk("setup_stable", (run >= 3), 1);
                end
                len++;
                if (wr_n !== 1'b0 || {a_d, bus_out} !== {s_ad, s_bus} || !bus_oe)
                    chk("strobe_stable", {bus_oe, wr_n, a_d, bus_out}, {2'b10, s_ad, s_bus});
            end else begin
                if (in_strobe) begin
                    in_strobe = 1'b0;
                    chk("strobe_len", len, 4);
                    if (exp_wr.size() == 0) chk("unexpected_write", {s_ad, s_bus}, 9'h000);
                    else chk("bus_write", {s_ad, s_bus}, exp_wr.pop_front());
                    post = 2;
                end
                if (post > 0) begin
                    chk("hold_stable", {bus_oe, a_d, bus_out}, {1'b1, s_ad, s_bus});
                    post--;
                end
            end

            if (after_done) chk("busy_after_done", busy, 0);
            after_done = done;
            busy_run = busy ? busy_run + 1 : 0;
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", done, 0);
                else chk("done_cycle", cyc, exp_done.pop_front());
                chk("busy_span", busy_run, 155);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        mem[0] = 8'h10; mem[1] = 8'h45; mem[2] = 8'h30; mem[3] = 8'h12;
        mem[4] = 8'h25; mem[5] = 8'h09; mem[6] = 8'h16;
        addr_tab[0] = 8'h02; addr_tab[1] = 8'h21; addr_tab[2] = 8'h22; addr_tab[3] = 8'h23;
        addr_tab[4] = 8'h24; addr_tab[5] = 8'h25; addr_tab[6] = 8'h26;
        reset = 1'b1;
        start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {a_d, cs_n, rd_n, wr_n, bus_oe, busy, done, ram_rd_en},
            8'b1111_0000);
        chk("rst_bus_out", bus_out, 8'h00);
        chk("rst_ram_addr", ram_addr, 3'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Plain sequence
        j = cyc; start = 1'b1; push_seq(j);
        @(negedge clk); start = 1'b0;
        wait_idle(400);

        // Mid-sequence start is ignored; RAM corrupted after hour byte is latched
        j = cyc; start = 1'b1; push_seq(j);
        @(negedge clk); start = 1'b0;
        while (cyc != j + 49) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc != j + 69) @(negedge clk);
        override = 1'b1;
        while (cyc != j + 88) @(negedge clk);
        override = 1'b0;
        wait_idle(400);

        // Reset during DATA_STROBE of entry 2 (clock 60)
        j = cyc; start = 1'b1; push_seq(j);
        @(negedge clk); start = 1'b0;
        while (cyc != j + 60) @(negedge clk);
        chk("pre_reset_strobe", {cs_n, wr_n, a_d}, 3'b001);
        #1;
        reset = 1'b1;
        exp_wr.delete();
        exp_done.delete();
        #1;
        chk("async_abort", {cs_n, wr_n, bus_oe, busy, done}, 5'b11000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", exp_done.size(), 0);

        // Full sequence from index 0 after reset
        j = cyc; start = 1'b1; push_seq(j);
        @(negedge clk); start = 1'b0;
        wait_idle(400);

        // start held for 300 clocks: exactly two back-to-back sequences
        j = cyc; start = 1'b1;
        push_seq(j);
        push_seq(j + 156);
        repeat (300) @(negedge clk);
        start = 1'b0;
        wait_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
Writes the time/date image held in the local RAM into the RTC over the multiplexed 8-bit bus (a_d, cs_n, rd_n, wr_n). It is the counterpart of the RTC read FSM, which copies the RTC into RAM.
- A start pulse walks a fixed 7-entry register table: control/command, sec, min, hour, day, month, year.
- For each entry it fetches the byte from RAM, then issues one address write cycle and one data write cycle.
- It sits between the RAM controller and the RTC bus pad logic.

Parameters:
- T_SETUP, 2, clocks with a_d and bus driven before the strobe.
- T_STROBE, 4, clocks with cs_n and wr_n low.
- T_HOLD, 2, clocks with bus held after the strobe is released.
- T_GAP, 2, idle clocks after each bus cycle.
- NUM_REGS, 7, number of table entries written per start.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a full write sequence; sampled only in IDLE
- busy  out  1  high from the first FETCH through DONE
- done  out  1  one-cycle pulse when the sequence completes
- ram_addr  out  3  RAM slot index (0..6)
- ram_rd_en  out  1  one-cycle RAM read strobe
- ram_rdata  in  8  RAM read data, valid one clock after ram_rd_en
- a_d  out  1  0 = address phase, 1 = data phase
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe; constantly 1
- wr_n  out  1  RTC write strobe, active low
- bus_out  out  8  byte driven toward the RTC
- bus_oe  out  1  tristate enable for bus_out

Behaviour:
- Reset (asynchronous, all outputs): a_d=1, cs_n=1, rd_n=1, wr_n=1, bus_oe=0, bus_out=0, busy=0, done=0, ram_rd_en=0, ram_addr=0. State=IDLE, index=0, timer=0.
- Reset during any state aborts the sequence on the spot; no partial strobe is completed.
- States: IDLE, FETCH, FETCH_WAIT, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, ADDR_GAP, DATA_SETUP, DATA_STROBE, DATA_HOLD, DATA_GAP, DONE.
- IDLE: start=1 at an edge -> FETCH with index=0. While busy, start is ignored and not queued.
- FETCH (1 clk): ram_rd_en=1, ram_addr=index.
- FETCH_WAIT (1 clk): ram_rdata is latched into data_reg at the end of this state.
- Address bus cycle:
  - ADDR_SETUP: a_d=0, bus_out=REG_ADDR[index], bus_oe=1, cs_n=wr_n=1.
  - ADDR_STROBE: as setup plus cs_n=0 and wr_n=0.
  - ADDR_HOLD: cs_n=wr_n=1, bus still driven.
  - ADDR_GAP: bus_oe stays 1; a_d switches to 1 at DATA_SETUP.
- Data bus cycle: same shape with a_d=1 and bus_out=data_reg.
- DATA_GAP: bus_oe=0.
- Each timed state lasts exactly its parameter count of clocks. The timer reloads on every state entry.
- After DATA_GAP: if index==NUM_REGS-1 go to DONE, else index+1 and go to FETCH.
- DONE (1 clk): done=1, busy=1; then IDLE. busy=0 in IDLE.
- Per-register cost with defaults: 2+8+2+8+2 = 22 clocks. The full sequence is 154 clocks. done is high in the 155th clock after the start-sampling edge.
- wr_n is never low unless cs_n is low. a_d and bus_out are stable for the whole strobe. rd_n is never asserted.
- data_reg holds its value through both bus cycles even if ram_rdata changes.
- A parameter value of 0 is illegal; the implementation may assert on it.

Decomposition:
Package rtc_pkg:
- REG_ADDR table: 0x02 control, 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year.
- State encoding enum.
- Default timing constants.

Sub-module rtc_bus_write_cycle:
- Performs one SETUP/STROBE/HOLD/GAP cycle.
- Inputs: go, a_d_val, byte.
- Output: cycle_done.
- The top FSM sequences fetch, address cycle and data cycle using it.

Test Plan:
- RAM preloaded with 0x10,0x45,0x30,0x12,0x25,0x09,0x16; start pulse -> seven address/data pairs observed, (0x02,0x10)(0x21,0x45)…(0x26,0x16); done once at clock 155; busy high for clocks 1..155.
- Strobe timing check (defaults) -> every cs_n low window is exactly 4 clks and wr_n matches it. a_d/bus_out are stable 2 clks before cs_n falls, through the strobe, and 2 clks after it rises. rd_n stays 1 throughout.
- start held high for 300 clks -> exactly two sequences. The second begins in the clock after DONE returns to IDLE.
- start re-pulsed mid-sequence at clk 50 -> ignored; a single done at clk 155.
- reset asserted at clk 60 (during a DATA_STROBE) -> cs_n/wr_n go to 1 and bus_oe to 0 asynchronously, and no done pulse appears. A new start after release writes the full 7 entries from index 0.
- ram_rdata forced to 0xFF after the latch cycle for entry 3 -> the RTC still receives the original latched value for hour.
